// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS control FSM with memory-ready stall timeout; define MULTICYCLE_CTRL_BNE_EN to add bne
module multicycle_ctrl #(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       err,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10,
    JUMP = 4'd11, ERROR = 4'd15
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
    OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t st, nx;
  logic [CNT_W-1:0] cnt;
  logic wait_st, stall_out, f_ok, is_br, take;
  logic pcen_r, irwrite_r, memwrite_r, regwrite_r;
  logic [2:0] f_alu;
  assign state = st;
  assign wait_st = st == FETCH || st == MEMRD || st == MEMWR;
  assign stall_out = STALL_LIMIT != 0 && !memready && cnt == CNT_W'(STALL_LIMIT);
`ifdef MULTICYCLE_CTRL_BNE_EN
  assign is_br = op == OP_BEQ || op == OP_BNE;
  assign take = op == OP_BNE ? ~zero : zero;
`else
  assign is_br = op == OP_BEQ;
  assign take = zero;
`endif
  always_comb begin
    f_ok = 1'b1;
    f_alu = 3'b010;
    case (funct)
      6'b100000: f_alu = 3'b010;
      6'b100010: f_alu = 3'b110;
      6'b100100: f_alu = 3'b000;
      6'b100101: f_alu = 3'b001;
      6'b101010: f_alu = 3'b111;
      default: f_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      cnt <= '0;
    end else begin
      st <= nx;
      cnt <= (memready || nx != st || !wait_st) ? '0 : cnt + 1'b1;
    end
  end
  // wait states: memready beats a timeout that lands in the same cycle
  always_comb begin
    nx = ERROR;
    case (st)
      FETCH:    nx = memready ? DECODE : stall_out ? ERROR : FETCH;
      DECODE:   nx = (op == OP_LW || op == OP_SW) ? MEMADR :
                     op == OP_R ? (f_ok ? EXECUTE : ERROR) :
                     is_br ? BRANCH : op == OP_ADDI ? ADDIEXEC : op == OP_J ? JUMP : ERROR;
      MEMADR:   nx = op == OP_LW ? MEMRD : op == OP_SW ? MEMWR : ERROR;
      MEMRD:    nx = memready ? MEMWB : stall_out ? ERROR : MEMRD;
      MEMWR:    nx = memready ? FETCH : stall_out ? ERROR : MEMWR;
      EXECUTE:  nx = ALUWB;
      ADDIEXEC: nx = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nx = FETCH;
      default:  nx = ERROR;
    endcase
  end
  always_comb begin
    pcen_r = 1'b0;
    irwrite_r = 1'b0;
    iord = 1'b0;
    memwrite_r = 1'b0;
    regwrite_r = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    alucontrol = 3'b000;
    err = 1'b0;
    case (st)
      FETCH:    begin alusrcb = 2'b01; alucontrol = 3'b010; irwrite_r = memready; pcen_r = memready; end
      DECODE:   begin alusrcb = 2'b11; alucontrol = 3'b010; end
      MEMADR:   begin alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010; end
      MEMRD:    iord = 1'b1;
      MEMWB:    begin memtoreg = 1'b1; regwrite_r = 1'b1; end
      MEMWR:    begin iord = 1'b1; memwrite_r = 1'b1; end
      EXECUTE:  begin alusrca = 1'b1; alucontrol = f_alu; end
      ALUWB:    begin regdst = 1'b1; regwrite_r = 1'b1; end
      BRANCH:   begin alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01; pcen_r = take; end
      ADDIEXEC: begin alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010; end
      ADDIWB:   regwrite_r = 1'b1;
      JUMP:     begin pcsrc = 2'b10; pcen_r = 1'b1; end
      ERROR:    err = 1'b1;
      default:  ;
    endcase
  end
  assign pcen = pcen_r & ~reset;
  assign irwrite = irwrite_r & ~reset;
  assign memwrite = memwrite_r & ~reset;
  assign regwrite = regwrite_r & ~reset;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction-level bench for multicycle_ctrl against a per-instruction state/output model
module tb_multicycle_ctrl;
  localparam int LIM = 15;
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECUTE = 6,
    ALUWB = 7, BRANCH = 8, ADDIEXEC = 9, ADDIWB = 10, JUMP = 11, ERROR = 15;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101,
    ADDI = 6'b001000, JMP = 6'b000010;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, memready = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  int n_cmp = 0, n_bad = 0;
  logic [5:0] legal_f [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic bit bne_on();
`ifdef MULTICYCLE_CTRL_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // {pcen,irwrite,iord,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,alucontrol,err}
  function automatic logic [15:0] exp_out(input int s, input logic mr);
    logic [15:0] v;
    logic tk;
    tk = (op == BNE && bne_on()) ? ~zero : zero;
    case (s)
      FETCH:    v = {mr, mr, 6'b000000, 2'b01, 2'b00, 3'b010, 1'b0};
      DECODE:   v = {8'b00000000, 2'b11, 2'b00, 3'b010, 1'b0};
      MEMADR:   v = {8'b00000001, 2'b10, 2'b00, 3'b010, 1'b0};
      MEMRD:    v = {8'b00100000, 2'b00, 2'b00, 3'b000, 1'b0};
      MEMWB:    v = {8'b00001010, 2'b00, 2'b00, 3'b000, 1'b0};
      MEMWR:    v = {8'b00110000, 2'b00, 2'b00, 3'b000, 1'b0};
      EXECUTE:  v = {8'b00000001, 2'b00, 2'b00, alu_of(funct), 1'b0};
      ALUWB:    v = {8'b00001100, 2'b00, 2'b00, 3'b000, 1'b0};
      BRANCH:   v = {tk, 7'b0000001, 2'b00, 2'b01, 3'b110, 1'b0};
      ADDIEXEC: v = {8'b00000001, 2'b10, 2'b00, 3'b010, 1'b0};
      ADDIWB:   v = {8'b00001000, 2'b00, 2'b00, 3'b000, 1'b0};
      JUMP:     v = {8'b10000000, 2'b00, 2'b10, 3'b000, 1'b0};
      default:  v = {8'b00000000, 2'b00, 2'b00, 3'b000, 1'b1};
    endcase
    if (reset) v = v & 16'h27FF;
    return v;
  endfunction

  function automatic logic [15:0] outs();
    return {pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol, err};
  endfunction

  task automatic step(input int s, input logic mr, input string tag);
    @(negedge clk);
    reset = 1'b0;
    memready = mr;
    #1;
    check({tag, " state"}, 16'(state), 16'(s));
    check({tag, " outs"}, outs(), exp_out(s, mr));
  endtask

  task automatic wait_phase(input int s, input int w, input string tag, output bit to);
    to = 1'b0;
    if (w > LIM) begin
      for (int i = 0; i <= LIM; i++) step(s, 1'b0, tag);
      to = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) step(s, 1'b0, tag);
      step(s, 1'b1, tag);
    end
  endtask

  // ERROR must hold with everything off until reset; the next step releases reset
  task automatic error_path(input string tag);
    for (int i = 0; i < 20; i++) step(ERROR, rb(), {tag, " err"});
    @(negedge clk);
    reset = 1'b1;
    memready = rb();
    #1;
    check({tag, " rst state"}, 16'(state), 16'(ERROR));
    check({tag, " rst outs"}, outs(), exp_out(ERROR, memready));
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int wf, input int wm, input string tag);
    bit to;
    op = o;
    funct = f;
    zero = z;
    wait_phase(FETCH, wf, tag, to);
    if (to) begin
      error_path(tag);
      return;
    end
    step(DECODE, rb(), tag);
    if (o == LW || o == SW) begin
      step(MEMADR, rb(), tag);
      wait_phase(o == LW ? MEMRD : MEMWR, wm, tag, to);
      if (to) error_path(tag);
      else if (o == LW) step(MEMWB, rb(), tag);
    end else if (o == 6'b000000 && funct_ok(f)) begin
      step(EXECUTE, rb(), tag);
      step(ALUWB, rb(), tag);
    end else if (o == BEQ || (o == BNE && bne_on())) begin
      step(BRANCH, rb(), tag);
    end else if (o == ADDI) begin
      step(ADDIEXEC, rb(), tag);
      step(ADDIWB, rb(), tag);
    end else if (o == JMP) begin
      step(JUMP, rb(), tag);
    end else begin
      error_path(tag);
    end
  endtask

  task automatic sw_reset();
    op = SW;
    funct = '0;
    zero = 1'b0;
    step(FETCH, 1'b1, "swrst");
    step(DECODE, rb(), "swrst");
    step(MEMADR, rb(), "swrst");
    step(MEMWR, 1'b0, "swrst");
    step(MEMWR, 1'b0, "swrst");
    @(negedge clk);
    reset = 1'b1;
    memready = rb();
    #1;
    check("swrst rst state", 16'(state), 16'(MEMWR));
    check("swrst rst memwrite", {15'b0, memwrite}, 16'h0000);
    check("swrst rst outs", outs(), exp_out(MEMWR, memready));
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(19, 0));
    return r < 12 ? 0 : r < 17 ? int'($urandom_range(4, 1)) : r == 17 ? LIM : LIM + 1;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 16'(state), 16'(FETCH));
    check("reset outs", outs(), exp_out(FETCH, memready));
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "add");
    run_instr(LW, 6'b000000, 1'b0, 0, 3, "lw wait3");
    run_instr(BEQ, 6'b000000, 1'b1, 0, 0, "beq z1");
    run_instr(BEQ, 6'b000000, 1'b0, 0, 0, "beq z0");
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal op");
    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, "illegal funct");
    run_instr(ADDI, 6'b000000, 1'b0, LIM + 1, 0, "fetch timeout");
    run_instr(ADDI, 6'b000000, 1'b0, LIM, 0, "fetch wait limit");
    run_instr(LW, 6'b000000, 1'b0, 0, LIM + 1, "memrd timeout");
    run_instr(SW, 6'b000000, 1'b0, 1, LIM, "sw wait limit");
    sw_reset();
    run_instr(JMP, 6'b000000, 1'b0, 0, 0, "j after swrst");
    run_instr(BNE, 6'b000000, 1'b0, 0, 0, "bne z0");
    run_instr(BNE, 6'b000000, 1'b1, 0, 0, "bne z1");
    for (int i = 0; i < 150; i++) begin
      logic [5:0] o, f;
      int k;
      k = int'($urandom_range(9, 0));
      f = legal_f[$urandom_range(4, 0)];
      case (k)
        0: o = LW;
        1: o = SW;
        4: o = BEQ;
        5: o = BNE;
        6: o = ADDI;
        7: o = JMP;
        8: o = 6'($urandom);
        default: begin
          o = 6'b000000;
          if ($urandom_range(7, 0) == 0) f = 6'($urandom);
        end
      endcase
      run_instr(o, f, rb(), pick_wait(), pick_wait(), "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
